// File: rtl/jt89_pkg.sv
// Shared constants for the jt89 tone-period decoder.
// Holds the lock FSM state encoding, the default timeout and the tone width.
package jt89_pkg;

  // Lock FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MEAS   = 2'd1;
  localparam logic [1:0] STEADY = 2'd2;

  // Default edge-less tick count before a constant level is declared
  localparam logic [10:0] TMO_DEF = 11'd1024;

  // Width of a recovered tone value
  localparam int unsigned TONEW = 10;

endpackage

// File: rtl/jt89_edge_cnt.sv
// Edge detector and saturating tick counter for the tone-period decoder.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   clk_en       - PSG tick enable; state only advances when high
//   din          - square-wave input, sampled on clk_en
//   edge_tick    - sampled din differs from the previous sample (this tick)
//   cnt          - ticks since the last edge; equals T at an edge T ticks after the previous one
//   tmo          - this tick brings cnt to TMO without an edge
module jt89_edge_cnt #(
  parameter int unsigned TMO = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        din,
  output logic        edge_tick,
  output logic [10:0] cnt,
  output logic        tmo
);

  localparam logic [10:0] TMO_C = 11'(TMO);

  logic din_d;

  assign edge_tick = clk_en && (din != din_d);
  // An edge on the same tick wins: that tick is a normal capture, not a timeout
  assign tmo       = clk_en && !edge_tick && (cnt >= TMO_C - 11'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      din_d <= 1'b0;
      cnt   <= 11'd0;
    end else if (clk_en) begin
      din_d <= din;
      if (edge_tick) begin
        cnt <= 11'd1;
      end else if (cnt >= TMO_C) begin
        cnt <= TMO_C;
      end else begin
        cnt <= cnt + 11'd1;
      end
    end
  end

endmodule

// File: rtl/jt89_tone_meas.sv
// Tone-period decoder: the inverse of the PSG tone channel.
// Measures the half-period of a square wave in clk_en ticks; a channel with
// tone value N yields half-period N. Reports N once STABLE_N consecutive
// captures agree, and flags a constant level after TMO edge-less ticks.
// Ports:
//   clk, rst - system clock, synchronous active-high reset
//   clk_en   - PSG tick enable
//   din      - square-wave input
//   tone     - recovered tone value (0 while steady)
//   valid    - tone holds a locked measurement (also set while steady)
//   steady   - no edge seen for TMO ticks
//   level    - last sampled din
//   upd      - one-clk pulse when tone or steady changes, or on a lock from
//              valid=0 (only when JT89_TONE_MEAS_EVT_EN is defined)
// Optional feature macro: JT89_TONE_MEAS_EVT_EN
module jt89_tone_meas
  import jt89_pkg::*;
#(
  parameter int unsigned STABLE_N = 2,
  parameter int unsigned TMO      = 32'(TMO_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             din,
  output logic [TONEW-1:0] tone,
  output logic             valid,
  output logic             steady,
  output logic             level
`ifdef JT89_TONE_MEAS_EVT_EN
  ,
  output logic             upd
`endif
);

  localparam logic [2:0] STABLE_W = 3'(STABLE_N);

  logic             edge_tick;
  logic [10:0]      cnt;
  logic             tmo;
  logic [TONEW-1:0] cap;
  logic             unused_cnt_msb;

  logic [1:0]       state_q, state_d;
  logic [TONEW-1:0] cand_q, cand_d;
  logic [2:0]       match_q, match_d;
  logic [TONEW-1:0] tone_q, tone_d;
  logic             valid_q, valid_d;
  logic             steady_q, steady_d;
  logic             level_q, level_d;

  jt89_edge_cnt #(
    .TMO (TMO)
  ) u_edge_cnt (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .din       (din),
    .edge_tick (edge_tick),
    .cnt       (cnt),
    .tmo       (tmo)
  );

  assign cap            = cnt[TONEW-1:0];
  assign unused_cnt_msb = cnt[10];

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    match_d  = match_q;
    tone_d   = tone_q;
    valid_d  = valid_q;
    steady_d = steady_q;
    level_d  = level_q;
    if (clk_en) begin
      level_d = din;
      case (state_q)
        IDLE: begin
          // First edge only starts timing; the interval before it is unknown
          if (edge_tick) begin
            state_d = MEAS;
            match_d = 3'd0;
          end else if (tmo) begin
            state_d  = STEADY;
            steady_d = 1'b1;
            valid_d  = 1'b1;
            tone_d   = '0;
            match_d  = 3'd0;
          end
        end
        MEAS: begin
          if (edge_tick) begin
            if ((cap == cand_q) && (match_q != 3'd0)) begin
              match_d = (match_q >= STABLE_W) ? match_q : match_q + 3'd1;
            end else begin
              cand_d  = cap;
              match_d = 3'd1;
            end
            // A mismatch leaves tone/valid alone until the new value locks
            if (match_d == STABLE_W) begin
              tone_d  = cand_d;
              valid_d = 1'b1;
            end
          end else if (tmo) begin
            state_d  = STEADY;
            steady_d = 1'b1;
            valid_d  = 1'b1;
            tone_d   = '0;
            match_d  = 3'd0;
          end
        end
        STEADY: begin
          if (edge_tick) begin
            state_d  = MEAS;
            match_d  = 3'd0;
            steady_d = 1'b0;
            valid_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      match_q  <= 3'd0;
      tone_q   <= '0;
      valid_q  <= 1'b0;
      steady_q <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      tone_q   <= tone_d;
      valid_q  <= valid_d;
      steady_q <= steady_d;
      level_q  <= level_d;
    end
  end

  assign tone   = tone_q;
  assign valid  = valid_q;
  assign steady = steady_q;
  assign level  = level_q;

`ifdef JT89_TONE_MEAS_EVT_EN
  logic upd_q, upd_d;

  // Lock from valid=0 counts even if the locked value equals the old tone
  always_comb begin
    upd_d = (tone_d != tone_q) || (steady_d != steady_q) ||
            (valid_d && !valid_q && (state_q == MEAS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_q <= 1'b0;
    end else begin
      upd_q <= upd_d;
    end
  end

  assign upd = upd_q;
`endif

endmodule

// File: doc/jt89_tone_meas.md
Name: jt89_tone_meas

Overview:
Tone-period decoder, the inverse of the PSG tone channel.
- Samples a square wave (a tone channel `out`, or an external PSG pin) on clk_en ticks and measures the half-period in ticks.
- Since a channel with tone value N holds each level for N ticks, the measured half-period equals N.
- Reports N once stable; flags a constant level (tone 0/1 sample-playback case).
- Used in the bench scoreboard and the OSD debug overlay.

Parameters:
- STABLE_N, 2: consecutive identical half-period captures required before tone_out updates (legal range 1..7).
- TMO, 1024: ticks without an edge before the steady (constant-level) state is declared; must be > 1023.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- clk_en, input, 1: PSG tick enable; all state advances only when high.
- din, input, 1: square-wave input, sampled on clk_en.
- tone, output, 10: recovered tone value (half-period in ticks).
- valid, output, 1: tone holds a locked measurement.
- steady, output, 1: no edge seen for TMO ticks.
- level, output, 1: last sampled din.

Behaviour:
- Reset values: tone=0, valid=0, steady=0, level=0. Internal state: state=IDLE, cnt=0, candidate=0, match=0, din_d=0.
- With clk_en low, all registers hold; din is ignored.
- Edge: an edge occurs on a tick where the sampled din differs from din_d. din_d and level are both updated every tick from the sampled din.
- Counter: 11-bit cnt.
  - On an edge tick, cnt is set to 1.
  - Otherwise cnt increments, saturating at TMO.
  - For edges T ticks apart, cnt equals T at the second edge.
- State IDLE:
  - Waits for the first edge. No capture occurs, because the previous interval is unknown.
  - On the first edge, moves to MEAS.
  - If cnt reaches TMO, moves to STEADY.
- State MEAS: on each edge tick, cap = cnt[9:0].
  - If cap == candidate and match > 0, match increments (saturating at STABLE_N).
  - Otherwise candidate <= cap and match <= 1.
  - When match reaches STABLE_N (including in the same tick as the update), tone <= candidate and valid <= 1, registered. Output latency is one clk after the locking edge tick.
  - A mismatch does not clear valid; the old tone is held until the new value locks.
  - If cnt reaches TMO (no edge), moves to STEADY.
- State STEADY:
  - steady=1, valid=1, tone=0.
  - On the next edge, moves to MEAS with cnt=1, match=0, and steady=0, valid=0 registered on that tick.
- Capture value 1 (edges on consecutive ticks) is legal and is reported as tone=1.
- Simultaneous events: an edge on the tick where cnt would reach TMO takes precedence; it is a normal capture of the value (TMO-1)[9:0].
- rst mid-measurement restores all reset values on the next clk, regardless of clk_en.

Optional Feature:
Macro JT89_TONE_MEAS_EVT_EN.
- Defined: adds output port `upd` (1 bit). It pulses high for exactly one clk whenever tone or steady changes value, including the lock from valid=0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package jt89_pkg holds:
  - state encoding: IDLE=2'd0, MEAS=2'd1, STEADY=2'd2.
  - default TMO constant, 11'd1024.
  - width constant TONEW=10.
- One natural sub-module, jt89_edge_cnt. It contains the din_d register, edge detect, and the saturating 11-bit counter; its outputs are edge, cnt and tmo.
- The lock state machine stays in the top.

Test Plan:
- Tone channel with tone=254 and clk_en every 16 clk, feeding din. After STABLE_N+1 edges: tone=254, valid=1, steady=0. The value stays stable over 20 edges.
- Tone value changed 254→3 mid-run. tone holds 254 with valid=1 until 2 equal captures of 3, then tone=3. With EVT_EN defined, exactly one upd pulse occurs.
- din held high for 1024 ticks (tone=1 case). steady=1, valid=1, tone=0 on the tick cnt hits 1024. A later edge clears steady and valid on the next clk.
- Tone value 1023. tone=1023 locks with no timeout. Edges 1024 ticks apart reach STEADY instead.
- Jitter pattern 10,11,10,11 half-periods. Never locks; valid stays 0 from reset.
- rst asserted mid-MEAS with clk_en=0. All outputs are 0 on the next clk. The first edge after reset produces no capture.
